mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/memory-stage port arbiter: FSM state
// encoding and the second-word address step direction.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SECOND = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic STEP_INC = 1'b0;
  localparam logic STEP_DEC = 1'b1;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, memory-stage and memory-array signals around the arbiter.
// Handshake: dm_req is held with stable operands until dm_done pulses; fetch is
// granted in the cycle if_stall is low and its data returns on if_valid next cycle.
interface mem_port_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_valid;
  logic [DW-1:0]   if_rdata;
  logic            if_stall;

  logic            dm_req;
  logic            dm_we;
  logic            dm_dbl;
  logic            dm_dir;
  logic [AW-1:0]   dm_addr;
  logic [2*DW-1:0] dm_wdata;
  logic            dm_done;
  logic [2*DW-1:0] dm_rdata;
  logic            dm_busy;

  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_dbl, dm_dir, dm_addr, dm_wdata, mem_rdata,
    output if_valid, if_rdata, if_stall, dm_done, dm_rdata, dm_busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Pipeline and memory-array side
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_dbl, dm_dir, dm_addr, dm_wdata, mem_rdata,
    input  if_valid, if_rdata, if_stall, dm_done, dm_rdata, dm_busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between fetch and the memory stage.
// Data accesses win; double-word accesses take two back-to-back cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output state_t              dbg_state_o
);

  function automatic logic [AW-1:0] step_addr(input logic [AW-1:0] a, input logic dir);
    logic [AW-1:0] one;
    one = {{(AW-1){1'b0}}, 1'b1};
    return (dir == STEP_DEC) ? (a - one) : (a + one);
  endfunction

  state_t        state_q;
  logic          if_valid_q;
  logic [DW-1:0] word0_q;
  logic          we_q;
  logic          dbl_q;
  logic [AW-1:0] addr2_q;
  logic [DW-1:0] wdata1_q;

  logic          grant;

  // Reset gates every combinational issue so an aborted access writes nothing more.
  always_comb begin
    grant = bus.if_req && !reset &&
            (((state_q == ST_IDLE) && !bus.dm_req) || (state_q == ST_RESP));
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (!reset) begin
      if ((state_q == ST_IDLE) && bus.dm_req) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.dm_we;
        bus.mem_addr  = bus.dm_addr;
        bus.mem_wdata = bus.dm_wdata[DW-1:0];
      end else if (state_q == ST_SECOND) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr2_q;
        bus.mem_wdata = wdata1_q;
      end else if (grant) begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.if_addr;
      end
    end
  end

  always_comb begin
    bus.dm_rdata = '0;
    if ((state_q == ST_RESP) && !we_q) begin
      bus.dm_rdata = dbl_q ? {bus.mem_rdata, word0_q} : {{DW{1'b0}}, bus.mem_rdata};
    end
  end

  assign bus.if_stall   = bus.if_req & ~grant;
  assign bus.if_valid   = if_valid_q;
  assign bus.if_rdata   = if_valid_q ? bus.mem_rdata : '0;
  assign bus.dm_done    = (state_q == ST_RESP) && !reset;
  assign bus.dm_busy    = (state_q != ST_IDLE);
  assign dbg_state_o    = state_q;

  // Operands for word 1 are latched at issue so the second cycle does not depend on the requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      if_valid_q <= 1'b0;
      word0_q    <= '0;
      we_q       <= 1'b0;
      dbl_q      <= 1'b0;
      addr2_q    <= '0;
      wdata1_q   <= '0;
    end else begin
      if_valid_q <= grant;
      case (state_q)
        ST_IDLE: begin
          if (bus.dm_req) begin
            we_q     <= bus.dm_we;
            dbl_q    <= bus.dm_dbl;
            addr2_q  <= step_addr(bus.dm_addr, bus.dm_dir);
            wdata1_q <= bus.dm_wdata[2*DW-1:DW];
            word0_q  <= '0;
            state_q  <= bus.dm_dbl ? ST_SECOND : ST_RESP;
          end
        end
        ST_SECOND: begin
          if (!we_q) word0_q <= bus.mem_rdata;
          state_q <= ST_RESP;
        end
        ST_RESP:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous-read memory.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DW(16), .AW(16)) bus ();
  state_t dbg_state;

  mem_port_arbiter #(.DW(16), .AW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .dbg_state_o(dbg_state)
  );

  logic [15:0] mem [0:65535];
  logic [15:0] mem_rdata_q = 16'h0;
  assign bus.mem_rdata = mem_rdata_q;

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    else if (bus.mem_en)          mem_rdata_q <= mem[bus.mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_dbl   = 1'b0;
    bus.dm_dir   = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
  endtask

  task automatic drive_dm(input logic we, input logic dbl, input logic dir,
                          input logic [15:0] addr, input logic [31:0] wdata);
    bus.dm_req   = 1'b1;
    bus.dm_we    = we;
    bus.dm_dbl   = dbl;
    bus.dm_dir   = dir;
    bus.dm_addr  = addr;
    bus.dm_wdata = wdata;
  endtask

  task automatic drive_if(input logic req, input logic [15:0] addr);
    bus.if_req  = req;
    bus.if_addr = addr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[16'h0010] = 16'hA5A5;
    mem[16'h0020] = 16'h5A5A;
    mem[16'h0040] = 16'h4444;
    mem[16'h0200] = 16'h1234;
    mem[16'h0FFE] = 16'h1111;
    mem[16'h0FFF] = 16'h2222;
    mem[16'h0501] = 16'h1357;
    mem[16'hFFFF] = 16'h0000;

    // Reset state
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    check("rst_done", bus.dm_done, 0);
    check("rst_busy", bus.dm_busy, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_if_valid", bus.if_valid, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    reset = 1'b0;

    // Fetch only
    @(negedge clk);
    drive_if(1'b1, 16'h0010);
    exp_q.push_back(32'hA5A5);
    #1;
    check("f_stall", bus.if_stall, 0);
    check("f_mem_addr", bus.mem_addr, 32'h0010);
    check("f_busy", bus.dm_busy, 0);
    @(negedge clk);
    drive_if(1'b0, 16'h0);
    #1;
    check("f_valid", bus.if_valid, 1);
    check("f_rdata", bus.if_rdata, exp_q.pop_front());

    // Single load against fetch
    @(negedge clk);
    drive_dm(1'b0, 1'b0, STEP_INC, 16'h0200, 32'h0);
    drive_if(1'b1, 16'h0020);
    #1;
    check("ld_stall_n", bus.if_stall, 1);
    check("ld_addr_n", bus.mem_addr, 32'h0200);
    @(negedge clk);
    exp_q.push_back(32'h5A5A);
    #1;
    check("ld_done", bus.dm_done, 1);
    check("ld_rdata", bus.dm_rdata, 32'h0000_1234);
    check("ld_stall_n1", bus.if_stall, 0);
    check("ld_fetch_addr", bus.mem_addr, 32'h0020);
    @(negedge clk);
    idle_inputs();
    #1;
    check("ld_done_clr", bus.dm_done, 0);
    check("ld_if_valid", bus.if_valid, 1);
    check("ld_if_rdata", bus.if_rdata, exp_q.pop_front());

    // Double push, stepping down through address zero
    @(negedge clk);
    drive_dm(1'b1, 1'b1, STEP_DEC, 16'h0000, 32'hBEEF_CAFE);
    drive_if(1'b1, 16'h0030);
    #1;
    check("push_stall_n", bus.if_stall, 1);
    check("push_we_n", bus.mem_we, 1);
    check("push_wd_n", bus.mem_wdata, 32'hCAFE);
    @(negedge clk);
    #1;
    check("push_stall_n1", bus.if_stall, 1);
    check("push_addr_n1", bus.mem_addr, 32'hFFFF);
    check("push_wd_n1", bus.mem_wdata, 32'hBEEF);
    check("push_done_n1", bus.dm_done, 0);
    @(negedge clk);
    #1;
    check("push_done", bus.dm_done, 1);
    check("push_rdata", bus.dm_rdata, 32'h0);
    check("push_stall_n2", bus.if_stall, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("push_mem0", mem[16'h0000], 32'hCAFE);
    check("push_memffff", mem[16'hFFFF], 32'hBEEF);

    // Double pop
    @(negedge clk);
    drive_dm(1'b0, 1'b1, STEP_INC, 16'h0FFE, 32'h0);
    #1;
    check("pop_addr_n", bus.mem_addr, 32'h0FFE);
    @(negedge clk);
    #1;
    check("pop_addr_n1", bus.mem_addr, 32'h0FFF);
    check("pop_we_n1", bus.mem_we, 0);
    @(negedge clk);
    #1;
    check("pop_done", bus.dm_done, 1);
    check("pop_rdata", bus.dm_rdata, 32'h2222_1111);
    @(negedge clk);
    idle_inputs();
    #1;
    check("pop_idle", dbg_state, ST_IDLE);

    // dm_req held past done: RESP ignores it, fetch takes the slot, reissue from IDLE
    @(negedge clk);
    drive_dm(1'b1, 1'b0, STEP_INC, 16'h0300, 32'h0000_7777);
    drive_if(1'b1, 16'h0040);
    #1;
    check("hold_stall_n", bus.if_stall, 1);
    @(negedge clk);
    exp_q.push_back(32'h4444);
    #1;
    check("hold_done_n1", bus.dm_done, 1);
    check("hold_stall_n1", bus.if_stall, 0);
    check("hold_fetch_addr", bus.mem_addr, 32'h0040);
    @(negedge clk);
    #1;
    check("hold_reissue_addr", bus.mem_addr, 32'h0300);
    check("hold_reissue_we", bus.mem_we, 1);
    check("hold_stall_n2", bus.if_stall, 1);
    check("hold_if_valid", bus.if_valid, 1);
    check("hold_if_rdata", bus.if_rdata, exp_q.pop_front());
    @(negedge clk);
    idle_inputs();
    #1;
    check("hold_done_n3", bus.dm_done, 1);
    @(negedge clk);
    #1;
    check("hold_mem", mem[16'h0300], 32'h7777);

    // Reset while in SECOND of a double write
    @(negedge clk);
    drive_dm(1'b1, 1'b1, STEP_INC, 16'h0500, 32'h9999_8888);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rs_state_second", dbg_state, ST_SECOND);
    check("rs_mem_en", bus.mem_en, 0);
    check("rs_done", bus.dm_done, 0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    check("rs_state", dbg_state, ST_IDLE);
    check("rs_done_after", bus.dm_done, 0);
    check("rs_busy", bus.dm_busy, 0);
    check("rs_mem_en_after", bus.mem_en, 0);
    check("rs_if_valid", bus.if_valid, 0);
    check("rs_word0", mem[16'h0500], 32'h8888);
    check("rs_word1", mem[16'h0501], 32'h1357);

    // Fetch request during reset produces no response
    @(negedge clk);
    reset = 1'b1;
    drive_if(1'b1, 16'h0010);
    #1;
    check("rf_mem_en", bus.mem_en, 0);
    check("rf_stall", bus.if_stall, 1);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    check("rf_if_valid", bus.if_valid, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
